// File: rtl/softmax_pkg.sv
// Shared types and constants for the softmax output serializer.
// Used by softmax_out_serializer and softmax_argmax_tracker.
package softmax_pkg;

    localparam int IDX_W = 6;
    localparam int LEN_W = IDX_W + 1;
    localparam logic [15:0] Q15_ONE = 16'h8000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    function automatic logic [LEN_W-1:0] decode_len(input logic [1:0] mode);
        logic [LEN_W-1:0] len;
        case (mode)
            2'b00:   len = LEN_W'(8);
            2'b01:   len = LEN_W'(16);
            2'b10:   len = LEN_W'(32);
            default: len = LEN_W'(64);
        endcase
        return len;
    endfunction

endpackage

// File: rtl/softmax_argmax_tracker.sv
// Running argmax over a stream of unsigned elements; ties keep the earliest index
// because an update needs a strictly greater value.
module softmax_argmax_tracker
    import softmax_pkg::*;
#(
    parameter int W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [W-1:0]     value,
    input  logic [IDX_W-1:0] idx,
    output logic [IDX_W-1:0] best_idx
);

    logic [W-1:0]     best_val_q, best_val_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_val_q <= '0;
            best_idx_q <= '0;
        end else begin
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
        end
    end

    always_comb begin
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        if (clear) begin
            best_val_d = '0;
            best_idx_d = '0;
        end else if (en && (value > best_val_q)) begin
            best_val_d = value;
            best_idx_d = idx;
        end
    end

    assign best_idx = best_idx_q;

endmodule

// File: rtl/softmax_out_serializer.sv
// Captures a softmax result vector, streams its active elements with ready/valid,
// then reports argmax. Build with SOFTMAX_SUM_CHECK_EN to add the sum_err check.
module softmax_out_serializer
    import softmax_pkg::*;
#(
    parameter int          N       = 64,
    parameter int          W       = 16,
    parameter int unsigned SUM_TOL = 32'h0100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_out,
    input  logic [N*W-1:0]   prob_flat,
    input  logic [1:0]       length_mode,
    output logic             busy,
    output logic [W-1:0]     s_data,
    output logic [IDX_W-1:0] s_idx,
    output logic             s_valid,
    input  logic             s_ready,
    output logic             s_last,
    output logic [IDX_W-1:0] argmax_idx,
    output logic             res_valid,
`ifdef SOFTMAX_SUM_CHECK_EN
    output logic             sum_err,
`endif
    output logic             overflow
);

    state_t state_q, state_d;

    logic [N*W-1:0]   prob_q, prob_d;
    logic [1:0]       mode_q, mode_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             overflow_q, overflow_d;

    logic [LEN_W-1:0] len;
    logic [W-1:0]     elem;
    logic             is_last;
    logic             capture;
    logic             xfer;

    assign len     = decode_len(mode_q);
    assign elem    = prob_q[int'(idx_q)*W +: W];
    assign is_last = ({1'b0, idx_q} == (len - LEN_W'(1)));
    assign capture = (state_q == ST_IDLE) && valid_out;
    assign xfer    = (state_q == ST_STREAM) && s_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (valid_out) state_d = ST_STREAM;
            ST_STREAM: if (s_ready && is_last) state_d = ST_REPORT;
            ST_REPORT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        s_idx     = '0;
        s_last    = 1'b0;
        res_valid = 1'b0;
        case (state_q)
            ST_STREAM: begin
                busy    = 1'b1;
                s_valid = 1'b1;
                s_data  = elem;
                s_idx   = idx_q;
                s_last  = is_last;
            end
            ST_REPORT: begin
                busy      = 1'b1;
                res_valid = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prob_q     <= '0;
            mode_q     <= '0;
            idx_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            prob_q     <= prob_d;
            mode_q     <= mode_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        prob_d     = prob_q;
        mode_d     = mode_q;
        idx_d      = idx_q;
        overflow_d = overflow_q | (valid_out && (state_q != ST_IDLE));
        if (capture) begin
            prob_d = prob_flat;
            mode_d = length_mode;
            idx_d  = '0;
        end else if (xfer) begin
            idx_d = idx_q + IDX_W'(1);
        end
    end

    assign overflow = overflow_q;

    softmax_argmax_tracker #(.W(W)) u_argmax (
        .clk      (clk),
        .rst      (rst),
        .clear    (capture),
        .en       (xfer),
        .value    (elem),
        .idx      (idx_q),
        .best_idx (argmax_idx)
    );

`ifdef SOFTMAX_SUM_CHECK_EN
    // W+6 bits holds 64 full-scale elements, so the accumulator cannot wrap.
    localparam int SUM_W = W + 6;
    localparam logic [SUM_W-1:0] ONE_EXT = SUM_W'(Q15_ONE);

    logic [SUM_W-1:0] sum_q, sum_d;
    logic [SUM_W-1:0] dev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    always_comb begin
        sum_d = sum_q;
        if (capture) begin
            sum_d = '0;
        end else if (xfer) begin
            sum_d = sum_q + SUM_W'(elem);
        end
    end

    assign dev     = (sum_q >= ONE_EXT) ? (sum_q - ONE_EXT) : (ONE_EXT - sum_q);
    assign sum_err = (state_q == ST_REPORT) && (dev > SUM_W'(SUM_TOL));
`endif

endmodule

// File: tb/tb_softmax_out_serializer.sv
// Randomized self-checking bench for softmax_out_serializer; checks sum_err
// only when built with SOFTMAX_SUM_CHECK_EN.
module tb_softmax_out_serializer;

    logic           clk = 1'b0;
    logic           rst;
    logic           valid_out;
    logic [1023:0]  prob_flat;
    logic [1:0]     length_mode;
    logic           busy;
    logic [15:0]    s_data;
    logic [5:0]     s_idx;
    logic           s_valid;
    logic           s_ready;
    logic           s_last;
    logic [5:0]     argmax_idx;
    logic           res_valid;
    logic           sum_err;
    logic           overflow;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] elem [64];
    bit exp_ovf = 1'b0;

    always #5 clk = ~clk;

    softmax_out_serializer dut (
        .clk         (clk),
        .rst         (rst),
        .valid_out   (valid_out),
        .prob_flat   (prob_flat),
        .length_mode (length_mode),
        .busy        (busy),
        .s_data      (s_data),
        .s_idx       (s_idx),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_last      (s_last),
        .argmax_idx  (argmax_idx),
        .res_valid   (res_valid),
`ifdef SOFTMAX_SUM_CHECK_EN
        .sum_err     (sum_err),
`endif
        .overflow    (overflow)
    );

`ifndef SOFTMAX_SUM_CHECK_EN
    assign sum_err = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // rmode: 0 = always ready, 1 = toggle every cycle, 2 = random
    task automatic run_vec(input logic [1:0] m, input int rmode, input bit dup);
        int L, k, cyc, exp_arg, dev;
        int unsigned sum;
        bit done, dup_done, exp_err;
        L = 8 << m;
        for (int i = L; i < 64; i++) elem[i] = 16'hFFFF;
        exp_arg = 0;
        sum = 0;
        for (int i = 0; i < L; i++) begin
            sum += elem[i];
            if (elem[i] > elem[exp_arg]) exp_arg = i;
        end
        dev = (sum > 32768) ? int'(sum) - 32768 : 32768 - int'(sum);
        exp_err = dev > 256;

        @(negedge clk);
        for (int i = 0; i < 64; i++) prob_flat[i*16 +: 16] = elem[i];
        length_mode = m;
        valid_out = 1'b1;
        @(negedge clk);
        valid_out = 1'b0;
        k = 0; cyc = 0; done = 1'b0; dup_done = 1'b0;
        while (!done && cyc < 1000) begin
            case (rmode)
                0:       s_ready = 1'b1;
                1:       s_ready = cyc[0];
                default: s_ready = 1'($urandom_range(0, 1));
            endcase
            if (dup && k == 3 && !dup_done) begin
                valid_out = 1'b1;
                prob_flat = {32{$urandom}};
                length_mode = ~m;
                dup_done = 1'b1;
                exp_ovf = 1'b1;
            end else begin
                valid_out = 1'b0;
            end
            chk("s_valid", s_valid, 1);
            chk("s_data", s_data, elem[k]);
            chk("s_idx", s_idx, k);
            chk("s_last", s_last, (k == L - 1));
            chk("res_valid_stream", res_valid, 0);
            if (s_ready) begin
                k++;
                if (k == L) done = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        valid_out = 1'b0;
        s_ready = 1'b0;
        chk("transfers_done", done, 1);
        chk("res_valid", res_valid, 1);
        chk("s_valid_report", s_valid, 0);
        chk("busy_report", busy, 1);
        chk("argmax_idx", argmax_idx, exp_arg);
`ifdef SOFTMAX_SUM_CHECK_EN
        chk("sum_err", sum_err, exp_err);
`endif
        chk("overflow", overflow, exp_ovf);
        repeat (2) begin
            @(negedge clk);
            chk("res_valid_after", res_valid, 0);
            chk("busy_after", busy, 0);
        end
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        valid_out = 1'b0;
        s_ready = 1'b0;
        prob_flat = '0;
        length_mode = 2'b00;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_s_valid", s_valid, 0);
        chk("rst_s_last", s_last, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_sum_err", sum_err, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_s_data", s_data, 0);
        chk("rst_s_idx", s_idx, 0);
        chk("rst_argmax", argmax_idx, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 64; i++) elem[i] = (i < 8) ? 16'h1000 : 16'h0000;
        run_vec(2'b00, 0, 1'b0);

        for (int i = 0; i < 64; i++) elem[i] = 16'($urandom_range(0, 16'h0100));
        elem[37] = 16'h4000;
        run_vec(2'b11, 1, 1'b0);

        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < 64; i++)
                elem[i] = (v[0]) ? 16'($urandom_range(0, 15)) : 16'($urandom_range(0, 16'h0800));
            run_vec(2'($urandom_range(0, 3)), 2, 1'b0);
        end

        for (int i = 0; i < 64; i++) elem[i] = 16'($urandom_range(0, 16'h7FFE));
        elem[3] = 16'h7FFF;
        elem[20] = 16'h7FFF;
        run_vec(2'b10, 2, 1'b0);

        for (int i = 0; i < 64; i++) elem[i] = 16'h0900;
        run_vec(2'b01, 0, 1'b0);
        for (int i = 0; i < 64; i++) elem[i] = 16'h0810;
        run_vec(2'b01, 2, 1'b0);
        for (int i = 0; i < 64; i++) elem[i] = 16'h0811;
        run_vec(2'b01, 0, 1'b0);
        for (int i = 0; i < 64; i++) elem[i] = 16'h07F0;
        run_vec(2'b01, 0, 1'b0);

        for (int i = 0; i < 64; i++) elem[i] = 16'($urandom_range(0, 16'h0400));
        run_vec(2'b01, 1, 1'b1);

        // abandon a vector with an asynchronous reset at idx 5
        for (int i = 0; i < 64; i++) elem[i] = 16'($urandom_range(0, 16'h0400));
        @(negedge clk);
        for (int i = 0; i < 64; i++) prob_flat[i*16 +: 16] = elem[i];
        length_mode = 2'b00;
        valid_out = 1'b1;
        @(negedge clk);
        valid_out = 1'b0;
        s_ready = 1'b1;
        cyc = 0;
        while (!(s_valid && s_idx == 6'd5) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("reach_idx5", s_idx, 5);
        #2 rst = 1'b1;
        #1;
        chk("arst_s_valid", s_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_s_idx", s_idx, 0);
        chk("arst_s_data", s_data, 0);
        chk("arst_argmax", argmax_idx, 0);
        chk("arst_overflow", overflow, 0);
        exp_ovf = 1'b0;
        s_ready = 1'b0;
        @(negedge clk);
        chk("arst_res_valid", res_valid, 0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_res_valid", res_valid, 0);
            chk("post_rst_busy", busy, 0);
        end
        run_vec(2'b00, 2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
